// File: rtl/button_debounce.sv
// button_debounce: two-flop synchroniser plus stable-count filter for a bouncy board input.
// Optional long-hold pulse is enabled by defining DEBOUNCE_LONG_PRESS_EN.
module button_debounce #(
    parameter logic        ACTIVE_LOW      = 1'b0,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned LONG_CYCLES     = 2000000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic signal_in,
    output logic signal_db,
    output logic press_pulse,
    output logic busy,
    output logic long_press
);
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {STABLE_OFF, PEND_ON, STABLE_ON, PEND_OFF} state_t;

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be >= 1");
    end
    if (LONG_CYCLES < 1) begin : g_bad_long
        $error("LONG_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    state_t state_q, state_d;
    logic [CW-1:0] count_q, count_d, count_inc;
    logic db_q, db_d, press_q, press_d, busy_q, busy_d;
    logic s_on, done;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], signal_in};
        s_on = sync_q[SYNC_STAGES-1] != ACTIVE_LOW;
        count_inc = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
        // >= rather than == lets DEBOUNCE_CYCLES==1 leave the pending state on its first cycle
        done = count_q >= CNT_LAST;
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        db_d = db_q;
        press_d = 1'b0;
        case (state_q)
            STABLE_OFF: begin
                state_d = s_on ? PEND_ON : STABLE_OFF;
                count_d = s_on ? CW'(1) : '0;
            end
            PEND_ON: begin
                if (!s_on) begin
                    state_d = STABLE_OFF;
                    count_d = '0;
                end else if (done) begin
                    state_d = STABLE_ON;
                    count_d = '0;
                    db_d = ~ACTIVE_LOW;
                    press_d = 1'b1;
                end else begin
                    count_d = count_inc;
                end
            end
            STABLE_ON: begin
                state_d = s_on ? STABLE_ON : PEND_OFF;
                count_d = s_on ? '0 : CW'(1);
            end
            PEND_OFF: begin
                if (s_on) begin
                    state_d = STABLE_ON;
                    count_d = '0;
                end else if (done) begin
                    state_d = STABLE_OFF;
                    count_d = '0;
                    db_d = ACTIVE_LOW;
                end else begin
                    count_d = count_inc;
                end
            end
            default: begin
                state_d = STABLE_OFF;
                count_d = '0;
                db_d = ACTIVE_LOW;
            end
        endcase
        busy_d = (state_d == PEND_ON) || (state_d == PEND_OFF);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
            state_q <= STABLE_OFF;
            count_q <= '0;
            db_q <= ACTIVE_LOW;
            press_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            state_q <= state_d;
            count_q <= count_d;
            db_q <= db_d;
            press_q <= press_d;
            busy_q <= busy_d;
        end
    end

    assign signal_db = db_q;
    assign press_pulse = press_q;
    assign busy = busy_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int unsigned HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

    logic [HW-1:0] hold_q, hold_d;
    logic long_q, long_d;

    always_comb begin
        hold_d = (state_q != STABLE_ON) ? '0 : (hold_q == HOLD_MAX) ? hold_q : hold_q + 1'b1;
        long_d = (state_q == STABLE_ON) && (hold_q == HOLD_MAX - 1'b1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press = long_q;
`else
    assign long_press = 1'b0;
`endif
endmodule

// File: tb/tb_button_debounce.sv
// tb_button_debounce: directed per-cycle checks of the debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=10.
module tb_button_debounce;
`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam bit LP = 1'b1;
`else
    localparam bit LP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic signal_in = 1'b0;
    logic signal_db, press_pulse, busy, long_press;
    int total = 0;
    int bad = 0;

    button_debounce #(
        .ACTIVE_LOW(1'b0),
        .SYNC_STAGES(2),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES(10)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .signal_in(signal_in),
        .signal_db(signal_db),
        .press_pulse(press_pulse),
        .busy(busy),
        .long_press(long_press)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [3:0] obs;
        reset_n = 1'b0;
        signal_in = 1'b0;
        #3;
        obs = {signal_db, press_pulse, busy, long_press};
        total++;
        if (obs !== 4'b0000) begin
            bad++;
            $display("FAIL reset_async got=%b exp=0000", obs);
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            obs = {signal_db, press_pulse, busy, long_press};
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL reset_idle n=%0d got=%b exp=0000", n, obs);
            end
        end
    endtask

    task automatic test_clean_rise;
        logic [3:0] obs, exp, m;
        signal_in = 1'b1;
        for (int n = 1; n <= 12; n++) begin
            tick();
            obs = {signal_db, press_pulse, busy, long_press};
            exp = {n >= 6, n == 6, n >= 3 && n <= 5, 1'b0};
            m = (n == 2) ? 4'b1101 : 4'b1111;
            total++;
            if ((obs & m) !== (exp & m)) begin
                bad++;
                $display("FAIL clean_rise n=%0d got=%b exp=%b mask=%b", n, obs, exp, m);
            end
        end
    endtask

    task automatic test_glitch_on;
        logic [3:0] obs, exp, m;
        signal_in = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            tick();
            if (n == 3) signal_in = 1'b1;
            obs = {signal_db, press_pulse, busy, long_press};
            exp = {1'b1, 1'b0, n == 4 || n == 5, 1'b0};
            m = (n == 3 || n == 6) ? 4'b1101 : 4'b1111;
            total++;
            if ((obs & m) !== (exp & m)) begin
                bad++;
                $display("FAIL glitch_on n=%0d got=%b exp=%b mask=%b", n, obs, exp, m);
            end
        end
    endtask

    task automatic test_release;
        logic [3:0] obs, exp, m;
        signal_in = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            tick();
            obs = {signal_db, press_pulse, busy, long_press};
            exp = {n < 6, 1'b0, n >= 3 && n <= 5, 1'b0};
            m = (n == 2) ? 4'b1101 : 4'b1111;
            total++;
            if ((obs & m) !== (exp & m)) begin
                bad++;
                $display("FAIL release n=%0d got=%b exp=%b mask=%b", n, obs, exp, m);
            end
        end
    endtask

    task automatic test_bounce;
        logic [3:0] obs, exp;
        logic [4:0] pat;
        pat = 5'b10101;
        signal_in = pat[0];
        for (int n = 1; n <= 14; n++) begin
            tick();
            signal_in = (n <= 4) ? pat[n] : 1'b1;
            obs = {signal_db, press_pulse, busy, long_press};
            exp = {n >= 10, n == 10, 1'b0, 1'b0};
            total++;
            if ((obs & 4'b1101) !== exp) begin
                bad++;
                $display("FAIL bounce n=%0d got=%b exp=%b (busy ignored)", n, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [3:0] obs;
        signal_in = 1'b0;
        for (int n = 1; n <= 10; n++) tick();
        total++;
        if (signal_db !== 1'b0) begin
            bad++;
            $display("FAIL mid_pre_off got=%b exp=0", signal_db);
        end
        signal_in = 1'b1;
        for (int n = 1; n <= 4; n++) tick();
        total++;
        if ({signal_db, busy} !== 2'b01) begin
            bad++;
            $display("FAIL mid_pending got=%b exp=01", {signal_db, busy});
        end
        reset_n = 1'b0;
        signal_in = 1'b0;
        #1;
        obs = {signal_db, press_pulse, busy, long_press};
        total++;
        if (obs !== 4'b0000) begin
            bad++;
            $display("FAIL mid_async got=%b exp=0000", obs);
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            tick();
            obs = {signal_db, press_pulse, busy, long_press};
            total++;
            if (obs !== 4'b0000) begin
                bad++;
                $display("FAIL mid_after n=%0d got=%b exp=0000", n, obs);
            end
        end
    endtask

    task automatic test_long_press;
        logic [3:0] obs, exp, m;
        signal_in = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            tick();
            obs = {signal_db, press_pulse, busy, long_press};
            exp = {n >= 6, n == 6, n >= 3 && n <= 5, LP && n == 16};
            m = (n == 2) ? 4'b1101 : 4'b1111;
            total++;
            if ((obs & m) !== (exp & m)) begin
                bad++;
                $display("FAIL long_press n=%0d got=%b exp=%b mask=%b", n, obs, exp, m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch_on();
        test_release();
        test_bounce();
        test_reset_mid();
        test_long_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
